// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   // Bits needed to count 0..value-1, never fewer than one.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(value)) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Combinational one-bit full adder, shared by the serial arithmetic blocks.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ cin;
   assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, with start/busy/done handshake.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CW = clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic [WIDTH-1:0] sum_next;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_co;

   full_adder_cell u_fa (
      .a   (a_sr[0]),
      .b   (b_sr[0]),
      .cin (carry),
      .s   (fa_s),
      .co  (fa_co)
   );

   // New bit enters at the MSB so the LSB computed first ends up at bit 0.
   always_comb begin
      sum_next            = sum_sr >> 1;
      sum_next[WIDTH-1]   = fa_s;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= StIdle;
         busy   <= 1'b0;
         done   <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf    <= 1'b0;
`endif
         cnt    <= '0;
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
      end else begin
         case (state)
            StIdle, StDone: begin
               done <= 1'b0;
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  carry <= cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= StRun;
               end else begin
                  state <= StIdle;
               end
            end
            StRun: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               sum_sr <= sum_next;
               carry  <= fa_co;
               cnt    <= cnt + CW'(1);
               if (cnt == LAST) begin
                  state <= StDone;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  sum   <= sum_next;
                  cout  <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
                  // On the MSB step, carry holds the carry into the MSB.
                  ovf   <= carry ^ fa_co;
`endif
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
